// File: rtl/ofmap_writeback.sv
// ofmap_writeback: per-lane bias / ReLU / shift / int16 saturation of the conv result
// stream, buffered in a small FIFO and written to the ofmap SRAM at sequential addresses.
module ofmap_writeback #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_num_out,
  input  logic [15:0]       cfg_bias_1,
  input  logic [15:0]       cfg_bias_2,
  input  logic              cfg_relu_en,
  input  logic [3:0]        cfg_shift,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  num_out_q, num_out_d;
  logic [15:0]        bias1_q, bias1_d;
  logic [15:0]        bias2_q, bias2_d;
  logic               relu_q, relu_d;
  logic [3:0]         shift_q, shift_d;
  logic               overflow_q, overflow_d;

  logic               s1_valid_q, s1_valid_d;
  logic signed [16:0] s1_sum1_q, s1_sum1_d;
  logic signed [16:0] s1_sum2_q, s1_sum2_d;
  logic               s2_valid_q, s2_valid_d;
  logic [31:0]        s2_data_q, s2_data_d;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic in_accept, fifo_full, push, pop, drop;

  // ReLU, then floor shift, then clamp to int16; a 17-bit sum never needs more room.
  function automatic logic [15:0] post_lane(input logic signed [16:0] sum,
                                            input logic relu, input logic [3:0] shamt);
    logic signed [16:0] v;
    v = (relu && sum < 0) ? 17'sd0 : sum;
    v = v >>> shamt;
    if (v > 17'sd32767)  return 16'h7fff;
    if (v < -17'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    in_accept  = (state_q == RUN) && in_valid && (in_cnt_q < num_out_q);
    s1_valid_d = in_accept;
    s1_sum1_d  = $signed({in_data[15], in_data[15:0]})  + $signed({bias1_q[15], bias1_q});
    s1_sum2_d  = $signed({in_data[31], in_data[31:16]}) + $signed({bias2_q[15], bias2_q});
    s2_valid_d = s1_valid_q;
    s2_data_d  = {post_lane(s1_sum2_q, relu_q, shift_q), post_lane(s1_sum1_q, relu_q, shift_q)};

    fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    pop       = (count_q != '0) && wr_ready;
    push      = s2_valid_q && (!fifo_full || pop);
    drop      = s2_valid_q && !push;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q + ADDR_W'(in_accept);
    wr_cnt_d   = wr_cnt_q + ADDR_W'(pop);
    overflow_d = overflow_q | drop;
    base_d     = base_q;
    num_out_d  = num_out_q;
    bias1_d    = bias1_q;
    bias2_d    = bias2_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d     = cfg_base;
        num_out_d  = cfg_num_out;
        bias1_d    = cfg_bias_1;
        bias2_d    = cfg_bias_2;
        relu_d     = cfg_relu_en;
        shift_d    = cfg_shift;
        overflow_d = 1'b0;
        in_cnt_d   = '0;
        wr_cnt_d   = '0;
        state_d    = RUN;
      end
      RUN:   if (in_cnt_d == num_out_q) state_d = DRAIN;
      DRAIN: if (!s1_valid_q && !s2_valid_q && count_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en    = (count_q != '0);
  assign wr_data  = wr_en ? mem_q[rd_ptr_q] : '0;
  assign wr_addr  = base_q + wr_cnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign overflow = overflow_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      base_q     <= '0;
      num_out_q  <= '0;
      bias1_q    <= '0;
      bias2_q    <= '0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sum1_q  <= '0;
      s1_sum2_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      base_q     <= base_d;
      num_out_q  <= num_out_d;
      bias1_q    <= bias1_d;
      bias2_q    <= bias2_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      s1_valid_q <= s1_valid_d;
      s1_sum1_q  <= s1_sum1_d;
      s1_sum2_q  <= s1_sum2_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define what is valid, and wr_data is gated when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s2_data_q;
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback: an integer-arithmetic model predicts every SRAM write,
// one monitor compares each write handshake, and per-job checks cover timing and flags.
module tb_ofmap_writeback;
  localparam int ADDR_W     = 13;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, start, cfg_relu_en, in_valid, wr_ready;
  logic [ADDR_W-1:0] cfg_base, cfg_num_out;
  logic [15:0]       cfg_bias_1, cfg_bias_2;
  logic [3:0]        cfg_shift;
  logic [31:0]       in_data;
  logic              wr_en, busy, done, overflow;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  always #5 clk = ~clk;

  ofmap_writeback #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_num_out(cfg_num_out),
    .cfg_bias_1(cfg_bias_1), .cfg_bias_2(cfg_bias_2),
    .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  logic [31:0]       data_log[$];
  logic [ADDR_W-1:0] addr_log[$];
  wr_t               mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int m_base, m_num, m_b1, m_b2, m_sh, m_acc, m_keep;
  bit m_relu;

  int writes_seen, done_cnt, done_cyc, first_wr_cyc, last_wr_cyc, start_cyc, first_beat_cyc;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_lane(input int x, input int b, input bit relu, input int sh);
    int s;
    s = x + b;
    if (relu && s < 0) s = 0;
    s = s >>> sh;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] d, input int b1, input int b2,
                                             input bit relu, input int sh);
    return {model_lane(int'($signed(d[31:16])), b2, relu, sh),
            model_lane(int'($signed(d[15:0])),  b1, relu, sh)};
  endfunction

  function automatic logic [31:0] data_at(input int i);
    return (data_log.size() > i) ? data_log[i] : 32'hdead_beef;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_at(input int i);
    return (addr_log.size() > i) ? addr_log[i] : '1;
  endfunction

  // Write-port monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check(wr_en && wr_addr == prev_addr && wr_data == prev_data, "hold_while_stalled",
              {19'd0, wr_addr, wr_data}, {19'd0, prev_addr, prev_data});
      if (wr_en && wr_ready) begin
        if (writes_seen == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        writes_seen++;
        data_log.push_back(wr_data);
        addr_log.push_back(wr_addr);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", {19'd0, wr_addr, wr_data}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check(wr_addr == mon_e.addr, "wr_addr", wr_addr, mon_e.addr);
          check(wr_data == mon_e.data, "wr_data", wr_data, mon_e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int num, input logic [15:0] b1, input logic [15:0] b2,
                          input bit relu, input int sh);
    cfg_base    = ADDR_W'(base);
    cfg_num_out = ADDR_W'(num);
    cfg_bias_1  = b1;
    cfg_bias_2  = b2;
    cfg_relu_en = relu;
    cfg_shift   = 4'(sh);
    m_base = base; m_num = num; m_b1 = int'($signed(b1)); m_b2 = int'($signed(b2));
    m_relu = relu; m_sh = sh; m_acc = 0; m_keep = 1 << 30;
    exp_q.delete(); data_log.delete(); addr_log.delete();
    writes_seen = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    if (m_acc < m_num) begin
      if (m_acc == 0) first_beat_cyc = cyc;
      if (m_acc < m_keep)
        exp_q.push_back({ADDR_W'(m_base + m_acc), model_word(d, m_b1, m_b2, m_relu, m_sh)});
      m_acc++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input int max_cycles, input bit exp_ovf);
    for (int i = 0; i < max_cycles && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(done_cnt > 0, "done_seen", done_cnt, 1);
    repeat (4) @(negedge clk);
    #1;
    check(done_cnt == 1, "done_single_pulse", done_cnt, 1);
    check(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
    check(overflow == exp_ovf, "overflow", overflow, exp_ovf);
    check(busy == 1'b0, "busy_after_done", busy, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b1;
    cfg_base = '0; cfg_num_out = '0; cfg_bias_1 = '0; cfg_bias_2 = '0;
    cfg_relu_en = 1'b0; cfg_shift = '0;
    writes_seen = 0; done_cnt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(wr_en == 1'b0,    "reset_wr_en",    wr_en,    0);
    check(wr_addr == '0,    "reset_wr_addr",  wr_addr,  0);
    check(wr_data == '0,    "reset_wr_data",  wr_data,  0);
    check(busy == 1'b0,     "reset_busy",     busy,     0);
    check(done == 1'b0,     "reset_done",     done,     0);
    check(overflow == 1'b0, "reset_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    tick();

    // Hand-derived values that pin the model.
    check(model_word(32'h7fff_8000, 32767, 32767, 1'b0, 0) == 32'h7fff_ffff, "model_pin_sat",
          model_word(32'h7fff_8000, 32767, 32767, 1'b0, 0), 32'h7fff_ffff);
    check(model_word(32'hfffe_0100, 16, -16, 1'b1, 1) == 32'h0000_0088, "model_pin_relu",
          model_word(32'hfffe_0100, 16, -16, 1'b1, 1), 32'h0000_0088);

    // Bias, ReLU, shift.  Lane1 of the third word: 32767+16 = 32783, >>1 = 16391 = 0x4007.
    do_start(0, 3, 16'h0010, 16'hfff0, 1'b1, 1);
    send(32'h0020_0030);
    send(32'hfffe_0100);
    send(32'h7fff_7fff);
    finish_job(30, 1'b0);
    check(data_at(0) == 32'h0008_0020, "brs_word0", data_at(0), 32'h0008_0020);
    check(data_at(1) == 32'h0000_0088, "brs_word1", data_at(1), 32'h0000_0088);
    check(data_at(2) == 32'h3ff7_4007, "brs_word2", data_at(2), 32'h3ff7_4007);

    // Saturation without ReLU.
    do_start(100, 1, 16'h7fff, 16'h7fff, 1'b0, 0);
    send(32'h7fff_8000);
    finish_job(30, 1'b0);
    check(data_at(0) == 32'h7fff_ffff, "sat_word", data_at(0), 32'h7fff_ffff);

    // Backpressure: only the first FIFO_DEPTH results survive.
    do_start(20, 8, 16'h0003, 16'hfffd, 1'b0, 0);
    m_keep = FIFO_DEPTH;
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h0010_0000 + 32'(i * 32'h0001_0101));
    repeat (6) tick();
    check(overflow == 1'b1, "bp_overflow_set", overflow, 1);
    check(busy == 1'b1,     "bp_busy_stalled", busy, 1);
    check(writes_seen == 0, "bp_no_writes_stalled", writes_seen, 0);
    wr_ready = 1'b1;
    finish_job(30, 1'b1);
    check(writes_seen == FIFO_DEPTH, "bp_write_count", writes_seen, FIFO_DEPTH);
    check(addr_at(3) == 23, "bp_last_addr", addr_at(3), 23);

    // Throughput, latency and address wrap.
    do_start(8190, 16, 16'h0100, 16'hff00, 1'b0, 2);
    for (int i = 0; i < 16; i++) send({16'(i * 4099), 16'(16'h8000 + i * 2311)});
    finish_job(40, 1'b0);
    check(first_wr_cyc - first_beat_cyc == 3, "latency", first_wr_cyc - first_beat_cyc, 3);
    check(writes_seen == 16, "tp_write_count", writes_seen, 16);
    check(last_wr_cyc - first_wr_cyc == 15, "tp_back_to_back", last_wr_cyc - first_wr_cyc, 15);
    check(done_cyc - last_wr_cyc == 2, "tp_done_delay", done_cyc - last_wr_cyc, 2);
    check(addr_at(0) == 8190, "tp_addr_first", addr_at(0), 8190);
    check(addr_at(2) == 0,    "tp_addr_wrap",  addr_at(2), 0);

    // Zero-length job.
    do_start(5, 0, 16'h0000, 16'h0000, 1'b0, 0);
    finish_job(10, 1'b0);
    check(writes_seen == 0, "zero_no_writes", writes_seen, 0);
    check(done_cyc - start_cyc <= 3, "zero_done_delay", done_cyc - start_cyc, 3);

    // Beats beyond num_out are ignored.
    do_start(200, 2, 16'h0001, 16'h0002, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(32'h0100_0200 + 32'(i));
    finish_job(30, 1'b0);
    check(writes_seen == 2, "extra_beats_ignored", writes_seen, 2);

    // start while busy is ignored.
    do_start(40, 3, 16'h0001, 16'h0002, 1'b0, 0);
    cfg_base = ADDR_W'(500); cfg_num_out = ADDR_W'(1); cfg_shift = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h0040_0080 + 32'(i * 3));
    finish_job(30, 1'b0);
    check(writes_seen == 3, "restart_ignored_count", writes_seen, 3);
    check(addr_at(0) == 40, "restart_ignored_base", addr_at(0), 40);

    // Reset mid-job.
    do_start(60, 5, 16'h0004, 16'h0005, 1'b0, 0);
    send(32'h0001_0001);
    send(32'h0002_0002);
    rst = 1'b1;
    tick();
    check(wr_en == 1'b0, "rst_mid_wr_en", wr_en, 0);
    check(busy == 1'b0,  "rst_mid_busy",  busy,  0);
    check(done == 1'b0,  "rst_mid_done",  done,  0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    check(writes_seen == 0 && done_cnt == 0, "rst_mid_no_activity", writes_seen + done_cnt, 0);
    do_start(60, 2, 16'h0004, 16'h0005, 1'b0, 0);
    send(32'h0003_0003);
    send(32'h0004_0004);
    finish_job(30, 1'b0);
    check(writes_seen == 2, "rst_rerun_count", writes_seen, 2);
    check(addr_at(0) == 60, "rst_rerun_base",  addr_at(0), 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
